uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares a single UART transmitter among `NUM_REQ` byte-stream requesters. Grants are held for a whole packet, from the first beat through the beat with `last` set. The arbiter sits between the requester FIFOs and the UART TX core and drives the TX core's valid/ready byte interface. A beat watchdog forces release of the grant when a packet runs longer than `MAX_PKT_LEN`.

## Interface

Parameters:
- `NUM_REQ`, default 4, number of requesters; legal range 2..16.
- `DATA_WIDTH`, default `uart_pkg::DATA_WIDTH` (8), byte width.
- `MAX_PKT_LEN`, default 64, maximum number of data beats per grant.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req_valid_i`, in, `NUM_REQ`: per-requester byte valid.
- `req_data_i`, in, `NUM_REQ*DATA_WIDTH`: requester k occupies bits `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `req_last_i`, in, `NUM_REQ`: marks the final byte of a packet.
- `req_ready_o`, out, `NUM_REQ`: per-requester byte accepted.
- `tx_valid_o`, out, 1: byte offered to the UART TX core.
- `tx_data_o`, out, `DATA_WIDTH`: byte to the UART TX core.
- `tx_ready_i`, in, 1: UART TX core accepts the byte.
- `grant_o`, out, `NUM_REQ`: one-hot current owner; all zero when idle.
- `busy_o`, out, 1: a grant is active.
- `trunc_o`, out, 1: one-cycle pulse when the watchdog forces a release.

## Operation

- FSM type is `arb_state_t`, with states `ARB_IDLE`, `ARB_HEADER` and `ARB_XFER`.
- **Arbitration in `ARB_IDLE`.** If any `req_valid_i` bit is set, register the grant to the first valid requester found searching from `last_gnt+1` upward, modulo `NUM_REQ`.
  - Next state is `ARB_XFER`, or `ARB_HEADER` when the header feature is compiled in.
- **Data transfer in `ARB_XFER`.**
  - Pure combinational pass-through for granted requester g: `tx_valid_o = req_valid_i[g]`, `tx_data_o = data[g]`, `req_ready_o[g] = tx_ready_i`.
  - All other `req_ready_o` bits are 0.
- **Beat accounting.** A beat is accepted when `tx_valid_o && tx_ready_i`. Each accepted beat increments `beat_cnt`, which is `$clog2(MAX_PKT_LEN+1)` bits wide.
- **Release.** On an accepted beat that has `req_last_i[g]` set, or that makes `beat_cnt == MAX_PKT_LEN`:
  - set `last_gnt <= g`, clear `beat_cnt`, return to `ARB_IDLE`;
  - if the release was caused by the count limit and `last` was not set, pulse `trunc_o`.
- **Gaps in requester valid.** If the granted requester drops `req_valid_i` mid-packet, the grant is held indefinitely. Only accepted beats count toward the watchdog.
- **Outputs when idle.** In `ARB_IDLE`, `tx_valid_o`, `tx_data_o` and `req_ready_o` are all 0.
- **Simultaneous last and limit.** `last` coinciding with the limit counts as a normal release; `trunc_o` stays 0.

## Timing

- **Reset values.** All outputs are 0. State is `ARB_IDLE`, `last_gnt = NUM_REQ-1` (so requester 0 wins first), `beat_cnt = 0`.
- **Grant latency.** `req_valid_i` seen in `ARB_IDLE` at cycle t gives `grant_o`/`busy_o` high at t+1. The first byte can be accepted at t+1, or at t+2 with the header feature.
- **Packet turnaround.** There is one mandatory `ARB_IDLE` bubble between consecutive packets, even from the same requester.
- **Backpressure.** While `tx_ready_i` is low, the requester must hold its data. The arbiter adds no registers on the data path.
- **Reset asserted mid-packet.** Outputs clear asynchronously. The partial packet is abandoned and requesters must restart it.

## Configuration

- `UART_ARB_HEADER_EN` defined:
  - After each grant, `ARB_HEADER` emits one byte equal to the granted index, zero-extended to `DATA_WIDTH`.
  - `tx_valid_o = 1` and all `req_ready_o` are 0 during this state.
  - Moves to `ARB_XFER` on `tx_ready_i`.
  - The header byte is not counted in `beat_cnt`.
- `UART_ARB_HEADER_EN` undefined: `ARB_HEADER` is unreachable and the grant goes straight to `ARB_XFER`.

## Structure

- `uart_pkg` gets the `arb_state_t` enum and a `MAX_PKT_LEN` default constant. `DATA_WIDTH` is reused from the package.
- One sub-module, `rr_picker`: combinational round-robin, with a `NUM_REQ` request vector and a `last_gnt` index as inputs, and a one-hot plus index as output.

## Test plan

- **Single requester, header off.** Requester 2 sends 0xA1, 0xA2, 0xA3 (last), `tx_ready_i=1` → `grant_o=4'b0100` one cycle after valid; three consecutive tx beats; `busy_o` falls after 0xA3.
- **Round-robin order.** All four requesters hold valid with 1-byte packets → grant order 0,1,2,3,0, with one idle cycle between each.
- **Backpressure.** `tx_ready_i` held low for 5 cycles mid-packet → `tx_data_o` stable, `req_ready_o` all 0, no beat counted, resumes afterwards.
- **Watchdog.** With `MAX_PKT_LEN=4`, requester 1 sends 6 bytes without last → `trunc_o` pulses on the 4th beat and requester 2, which is valid, is granted next.
- **Reset mid-packet.** `rst_n` goes low mid-packet → all outputs are 0 in the same cycle; after release, requester 0 wins over requester 3 when both are valid.
- **Header feature.** With `UART_ARB_HEADER_EN`, requester 3 sends 0x55 (last) → tx sees 0x03 then 0x55, and `beat_cnt` reaches only 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit path and its requester arbiter.
package uart_pkg;

  localparam int DATA_WIDTH  = 8;
  localparam int MAX_PKT_LEN = 64;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_HEADER = 2'd1,
    ARB_XFER   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin pick: first set request searching upward from last_gnt+1.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_gnt,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               req_any
);

  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    return IDX_W'(v % NUM_REQ);
  endfunction

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    req_any = 1'b0;
    // Offsets 1..NUM_REQ so the previous owner is considered last.
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!req_any && req[wrap_idx(int'(last_gnt) + i)]) begin
        req_any = 1'b1;
        gnt_idx = wrap_idx(int'(last_gnt) + i);
        gnt_oh[wrap_idx(int'(last_gnt) + i)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART TX byte interface among NUM_REQ requesters.
// Optional per-grant index header byte is compiled in with UART_ARB_HEADER_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = uart_pkg::DATA_WIDTH,
  parameter int MAX_PKT_LEN = uart_pkg::MAX_PKT_LEN
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          tx_valid_o,
  output logic [DATA_WIDTH-1:0]         tx_data_o,
  input  logic                          tx_ready_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o,
  output logic                          trunc_o
);
  import uart_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_PKT_LEN + 1);

  arb_state_t         state, nxt_state;
  logic [IDX_W-1:0]   gnt_idx, last_gnt, pick_idx;
  logic [NUM_REQ-1:0] gnt_oh, pick_oh;
  logic               pick_any;
  logic [CNT_W-1:0]   beat_cnt, cnt_inc;
  logic               beat, at_limit, release_pkt;

  rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .req      (req_valid_i),
    .last_gnt (last_gnt),
    .gnt_oh   (pick_oh),
    .gnt_idx  (pick_idx),
    .req_any  (pick_any)
  );

  assign cnt_inc = beat_cnt + CNT_W'(1);
  assign busy_o  = (state != ARB_IDLE);
  assign grant_o = busy_o ? gnt_oh : '0;

  always_comb begin
    nxt_state   = state;
    tx_valid_o  = 1'b0;
    tx_data_o   = '0;
    req_ready_o = '0;
    beat        = 1'b0;
    at_limit    = 1'b0;
    release_pkt = 1'b0;
    trunc_o     = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (pick_any) begin
`ifdef UART_ARB_HEADER_EN
          nxt_state = ARB_HEADER;
`else
          nxt_state = ARB_XFER;
`endif
        end
      end
      ARB_HEADER: begin
`ifdef UART_ARB_HEADER_EN
        tx_valid_o = 1'b1;
        tx_data_o  = DATA_WIDTH'(gnt_idx);
        if (tx_ready_i) nxt_state = ARB_XFER;
`else
        nxt_state = ARB_IDLE;
`endif
      end
      ARB_XFER: begin
        tx_valid_o           = req_valid_i[gnt_idx];
        tx_data_o            = req_data_i[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
        req_ready_o[gnt_idx] = tx_ready_i;
        beat                 = req_valid_i[gnt_idx] && tx_ready_i;
        at_limit             = beat && (cnt_inc == CNT_W'(MAX_PKT_LEN));
        release_pkt          = beat && (req_last_i[gnt_idx] || at_limit);
        // A limit hit that coincides with last is an ordinary end of packet.
        trunc_o              = at_limit && !req_last_i[gnt_idx];
        if (release_pkt) nxt_state = ARB_IDLE;
      end
      default: nxt_state = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      gnt_idx  <= '0;
      gnt_oh   <= '0;
      last_gnt <= IDX_W'(NUM_REQ - 1);
      beat_cnt <= '0;
    end else begin
      state <= nxt_state;
      if (state == ARB_IDLE && pick_any) begin
        gnt_idx <= pick_idx;
        gnt_oh  <= pick_oh;
      end
      if (release_pkt) begin
        last_gnt <= gnt_idx;
        beat_cnt <= '0;
      end else if (beat) begin
        beat_cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter (4 requesters, 8-bit bytes, packet limit 4).
module tb_uart_tx_arbiter;
  localparam int NR  = 4;
  localparam int DW  = 8;
  localparam int MPL = 4;
`ifdef UART_ARB_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid_i;
  logic [NR*DW-1:0] req_data_i;
  logic [NR-1:0]    req_last_i;
  logic [NR-1:0]    req_ready_o;
  logic             tx_valid_o;
  logic [DW-1:0]    tx_data_o;
  logic             tx_ready_i;
  logic [NR-1:0]    grant_o;
  logic             busy_o;
  logic             trunc_o;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] gnt;
    logic [3:0] rdy;
    logic       trunc;
  } exp_t;

  exp_t       sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [8:0] mem [NR][16];
  int         head [NR];
  int         tail [NR];
  logic       flush;
  logic [NR-1:0] fire;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_PKT_LEN(MPL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .tx_valid_o  (tx_valid_o),
    .tx_data_o   (tx_data_o),
    .tx_ready_i  (tx_ready_i),
    .grant_o     (grant_o),
    .busy_o      (busy_o),
    .trunc_o     (trunc_o)
  );

  function automatic logic [3:0] oh(input int g);
    return 4'(1 << g);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int k, input logic [7:0] d, input logic last);
    mem[k][tail[k]] = {last, d};
    tail[k]++;
  endtask

  task automatic exp_hdr(input int g);
    if (HDR != 0) sb.push_back('{data: 8'(g), gnt: oh(g), rdy: 4'h0, trunc: 1'b0});
  endtask

  task automatic exp_beat(input int g, input logic [7:0] d, input logic tr);
    sb.push_back('{data: d, gnt: oh(g), rdy: oh(g), trunc: tr});
  endtask

  task automatic wait_grant(input string name, input logic [3:0] exp_oh, input int budget);
    int i = 0;
    while (grant_o == 4'h0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(name, 32'(grant_o), 32'(exp_oh));
  endtask

  task automatic wait_sb(input string name, input int budget, input logic need_idle);
    int i = 0;
    while ((sb.size() != 0 || (need_idle && busy_o)) && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(name, 32'(sb.size()), 32'd0);
  endtask

  // Requester model: presents queue heads, pops on a handshake seen before the edge.
  initial begin
    req_valid_i = '0;
    req_data_i  = '0;
    req_last_i  = '0;
    for (int k = 0; k < NR; k++) head[k] = 0;
    forever begin
      @(negedge clk);
      fire = req_valid_i & req_ready_o;
      @(posedge clk);
      #1;
      for (int k = 0; k < NR; k++) begin
        if (flush) head[k] = tail[k];
        else if (fire[k]) head[k]++;
        if (head[k] < tail[k]) begin
          req_valid_i[k]         = 1'b1;
          req_data_i[k*DW +: DW] = mem[k][head[k]][7:0];
          req_last_i[k]          = mem[k][head[k]][8];
        end else begin
          req_valid_i[k]         = 1'b0;
          req_data_i[k*DW +: DW] = '0;
          req_last_i[k]          = 1'b0;
        end
      end
    end
  end

  // Monitor: every accepted TX byte is matched against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx_valid_o === 1'b1 && tx_ready_i === 1'b1) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got data %0h grant %0h, expected no beat (t=%0t)",
                   tx_data_o, grant_o, $time);
        end else begin
          e = sb.pop_front();
          check("tx_beat{data,grant,ready,trunc}",
                32'({tx_data_o, grant_o, req_ready_o, trunc_o}), 32'(e));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    int order[5] = '{0, 1, 2, 3, 0};
    rst_n      = 1'b0;
    tx_ready_i = 1'b1;
    flush      = 1'b0;
    for (int k = 0; k < NR; k++) tail[k] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'({grant_o, busy_o, tx_valid_o, tx_data_o, req_ready_o, trunc_o}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outputs", 32'({grant_o, busy_o, tx_valid_o, tx_data_o, req_ready_o, trunc_o}), 32'd0);

    // Single requester, three-byte packet.
    exp_hdr(2);
    exp_beat(2, 8'hA1, 1'b0);
    exp_beat(2, 8'hA2, 1'b0);
    exp_beat(2, 8'hA3, 1'b0);
    push(2, 8'hA1, 1'b0);
    push(2, 8'hA2, 1'b0);
    push(2, 8'hA3, 1'b1);
    @(negedge clk);
    check("t1_no_grant_yet", 32'(grant_o), 32'd0);
    @(negedge clk);
    check("t1_grant_busy", 32'({busy_o, grant_o}), 32'({1'b1, 4'b0100}));
    repeat (2 + HDR) @(negedge clk);
    check("t1_busy_last_byte", 32'(busy_o), 32'd1);
    @(negedge clk);
    check("t1_busy_fall", 32'(busy_o), 32'd0);
    wait_sb("t1_drain", 20, 1'b1);

    // Round robin from a fresh reset: 0,1,2,3,0 with one idle cycle between.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int p = 0; p < 5; p++) begin
      exp_hdr(order[p]);
      exp_beat(order[p], 8'hB0 + 8'(p), 1'b0);
      push(order[p], 8'hB0 + 8'(p), 1'b1);
    end
    wait_grant("t2_first_grant", oh(0), 10);
    for (int p = 0; p < 5; p++) begin
      for (int j = 0; j <= HDR; j++) begin
        check("t2_grant", 32'(grant_o), 32'(oh(order[p])));
        @(negedge clk);
      end
      check("t2_bubble", 32'(grant_o), 32'd0);
      @(negedge clk);
    end
    wait_sb("t2_drain", 20, 1'b1);

    // Backpressure mid-packet; last on the 4th beat lands on the limit without truncation.
    exp_hdr(1);
    for (int b = 1; b <= 4; b++) begin
      exp_beat(1, 8'hC0 + 8'(b), 1'b0);
      push(1, 8'hC0 + 8'(b), b == 4);
    end
    wait_grant("t3_grant", oh(1), 10);
    repeat (HDR) @(negedge clk);
    @(posedge clk);
    #2 tx_ready_i = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("t3_hold_data", 32'({tx_valid_o, tx_data_o}), 32'({1'b1, 8'hC2}));
      check("t3_no_ready", 32'(req_ready_o), 32'd0);
    end
    @(posedge clk);
    #2 tx_ready_i = 1'b1;
    wait_sb("t3_drain", 20, 1'b1);

    // Watchdog: six bytes without last from requester 1, requester 2 waiting.
    exp_hdr(1);
    for (int b = 1; b <= 4; b++) exp_beat(1, 8'hD0 + 8'(b), b == 4);
    exp_hdr(2);
    exp_beat(2, 8'hE1, 1'b0);
    exp_hdr(1);
    exp_beat(1, 8'hD5, 1'b0);
    exp_beat(1, 8'hD6, 1'b0);
    for (int b = 1; b <= 6; b++) push(1, 8'hD0 + 8'(b), 1'b0);
    wait_grant("t4_grant", oh(1), 10);
    push(2, 8'hE1, 1'b1);
    wait_sb("t4_drain", 40, 1'b0);
    repeat (3) @(negedge clk);
    check("t4_gap_hold", 32'({busy_o, grant_o}), 32'({1'b1, 4'b0010}));

    // Reset mid-packet with a byte pending under backpressure.
    @(posedge clk);
    #2 tx_ready_i = 1'b0;
    push(1, 8'hD7, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("t5_pending", 32'({tx_valid_o, tx_data_o, req_ready_o}), 32'({1'b1, 8'hD7, 4'h0}));
    #2 rst_n = 1'b0;
    #1;
    check("t5_reset_async", 32'({grant_o, busy_o, tx_valid_o, tx_data_o, req_ready_o, trunc_o}), 32'd0);
    flush = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    flush      = 1'b0;
    tx_ready_i = 1'b1;
    exp_hdr(0);
    exp_beat(0, 8'hF0, 1'b0);
    exp_hdr(3);
    exp_beat(3, 8'hF3, 1'b0);
    push(0, 8'hF0, 1'b1);
    push(3, 8'hF3, 1'b1);
    wait_grant("t5_first_grant", oh(0), 10);
    wait_sb("t5_drain", 20, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
